// File: rtl/multicycle_addsub.sv
// Chunk-serial signed/unsigned adder-subtractor: CHUNK bits per cycle, LSB chunk first.
// Optional saturation on overflow when ADDSUB_SAT_EN is defined (adds the Sat input).
module multicycle_addsub #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             Start,
    input  logic             Sub,
    input  logic             CIn,
`ifdef ADDSUB_SAT_EN
    input  logic             Sat,
`endif
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Sum,
    output logic             COut,
    output logic             Overflow,
    output logic             Zero,
    output logic             Busy,
    output logic             Done
);

    localparam int unsigned NCH = WIDTH / CHUNK;
    localparam int unsigned IW  = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] shadow_q;
    logic             carry_q;
    logic [IW-1:0]    idx_q;
`ifdef ADDSUB_SAT_EN
    logic             sat_q;
`endif

    logic [CHUNK:0]   part;
    logic [WIDTH-1:0] shadow_d;
    logic [WIDTH-1:0] result;
    logic             a_msb;
    logic             b_msb;
    logic             ovf;
    logic             last;

    // Operands shift right each cycle, so the active chunk is always the low CHUNK bits;
    // the shadow fills from the top so it is fully aligned after NCH chunks.
    always_comb begin
        part     = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]} + {{CHUNK{1'b0}}, carry_q};
        shadow_d = (shadow_q >> CHUNK) | (WIDTH'(part[CHUNK-1:0]) << (WIDTH - CHUNK));
        a_msb    = a_q[CHUNK-1];
        b_msb    = b_q[CHUNK-1];
        // Same-sign operands producing a different-sign result == carry-in(MSB) ^ carry-out
        ovf      = (a_msb ~^ b_msb) & (a_msb ^ part[CHUNK-1]);
        result   = shadow_d;
`ifdef ADDSUB_SAT_EN
        if (sat_q && ovf) begin
            result = {a_msb, {(WIDTH-1){~a_msb}}};
        end
`endif
        last     = (idx_q == IW'(NCH - 1));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            a_q      <= '0;
            b_q      <= '0;
            shadow_q <= '0;
            carry_q  <= 1'b0;
            idx_q    <= '0;
`ifdef ADDSUB_SAT_EN
            sat_q    <= 1'b0;
`endif
            Sum      <= '0;
            COut     <= 1'b0;
            Overflow <= 1'b0;
            Zero     <= 1'b0;
            Busy     <= 1'b0;
            Done     <= 1'b0;
        end else begin
            case (state_q)
                StIdle, StDone: begin
                    Done <= 1'b0;
                    if (Start) begin
                        a_q     <= A;
                        b_q     <= Sub ? ~B : B;
                        carry_q <= CIn ^ Sub;
                        idx_q   <= '0;
`ifdef ADDSUB_SAT_EN
                        sat_q   <= Sat;
`endif
                        Busy    <= 1'b1;
                        state_q <= StCalc;
                    end else begin
                        state_q <= StIdle;
                    end
                end
                StCalc: begin
                    a_q      <= a_q >> CHUNK;
                    b_q      <= b_q >> CHUNK;
                    shadow_q <= shadow_d;
                    carry_q  <= part[CHUNK];
                    idx_q    <= idx_q + IW'(1);
                    if (last) begin
                        Sum      <= result;
                        COut     <= part[CHUNK];
                        Overflow <= ovf;
                        Zero     <= (result == '0);
                        Busy     <= 1'b0;
                        Done     <= 1'b1;
                        idx_q    <= '0;
                        state_q  <= StDone;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_addsub.sv
// Bench for multicycle_addsub: three configurations (16/4, 16/16, 32/8) against an
// arithmetic reference model; define ADDSUB_SAT_EN to also exercise saturation.
module tb_multicycle_addsub;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  start;
    logic        sub, cin, sat;
    logic [31:0] a, b;
    logic [15:0] s0, s1;
    logic [31:0] s2;
    logic [2:0]  cout_o, ovf_o, zero_o, busy_o, done_o;

    int n_total = 0;
    int n_pass  = 0;
    bit chk_en  = 1'b0;

    always #5 clk = ~clk;

    multicycle_addsub #(.WIDTH(16), .CHUNK(4)) u_d0 (
        .clk(clk), .rst_n(rst_n), .Start(start[0]), .Sub(sub), .CIn(cin),
`ifdef ADDSUB_SAT_EN
        .Sat(sat),
`endif
        .A(a[15:0]), .B(b[15:0]), .Sum(s0), .COut(cout_o[0]), .Overflow(ovf_o[0]),
        .Zero(zero_o[0]), .Busy(busy_o[0]), .Done(done_o[0])
    );

    multicycle_addsub #(.WIDTH(16), .CHUNK(16)) u_d1 (
        .clk(clk), .rst_n(rst_n), .Start(start[1]), .Sub(sub), .CIn(cin),
`ifdef ADDSUB_SAT_EN
        .Sat(sat),
`endif
        .A(a[15:0]), .B(b[15:0]), .Sum(s1), .COut(cout_o[1]), .Overflow(ovf_o[1]),
        .Zero(zero_o[1]), .Busy(busy_o[1]), .Done(done_o[1])
    );

    multicycle_addsub #(.WIDTH(32), .CHUNK(8)) u_d2 (
        .clk(clk), .rst_n(rst_n), .Start(start[2]), .Sub(sub), .CIn(cin),
`ifdef ADDSUB_SAT_EN
        .Sat(sat),
`endif
        .A(a), .B(b), .Sum(s2), .COut(cout_o[2]), .Overflow(ovf_o[2]),
        .Zero(zero_o[2]), .Busy(busy_o[2]), .Done(done_o[2])
    );

    function automatic int wid_of(input int d);
        return (d == 2) ? 32 : 16;
    endfunction

    function automatic int nch_of(input int d);
        return (d == 1) ? 1 : 4;
    endfunction

    function automatic logic [31:0] dut_sum(input int d);
        case (d)
            0:       return {16'd0, s0};
            1:       return {16'd0, s1};
            default: return s2;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, got, exp, $time);
    endtask

    // ---------------- reference model ----------------
    logic [31:0] m_a[3], m_b[3], m_sum[3];
    logic        m_sub[3], m_cin[3], m_sat[3];
    logic        m_busy[3], m_done[3], m_cout[3], m_ovf[3], m_zero[3];
    int          m_rem[3];

    task automatic finish_op(input int d);
        longint one = 1;
        longint w, mask, ua, ub, ci, sa, sb, raw, ideal, res;
        logic   ovf;
        w    = longint'(wid_of(d));
        mask = (one << w) - 1;
        ua   = longint'(m_a[d]) & mask;
        ub   = longint'(m_b[d]) & mask;
        ci   = m_cin[d] ? 1 : 0;
        sa   = (((ua >> (w - 1)) & 1) != 0) ? ua - (one << w) : ua;
        sb   = (((ub >> (w - 1)) & 1) != 0) ? ub - (one << w) : ub;
        if (m_sub[d]) begin
            raw       = ua - ub - ci;
            ideal     = sa - sb - ci;
            m_cout[d] = (ua >= ub + ci);
        end else begin
            raw       = ua + ub + ci;
            ideal     = sa + sb + ci;
            m_cout[d] = ((raw >> w) & 1) != 0;
        end
        ovf = (ideal > (one << (w - 1)) - 1) || (ideal < -(one << (w - 1)));
        res = raw & mask;
        if (m_sat[d] && ovf) res = (sa < 0) ? (one << (w - 1)) : (one << (w - 1)) - 1;
        m_sum[d]  = 32'(res);
        m_ovf[d]  = ovf;
        m_zero[d] = (res == 0);
        m_busy[d] = 1'b0;
        m_done[d] = 1'b1;
    endtask

    initial begin
        for (int d = 0; d < 3; d++) begin
            m_sum[d] = '0; m_busy[d] = 0; m_done[d] = 0; m_cout[d] = 0;
            m_ovf[d] = 0; m_zero[d] = 0; m_rem[d] = 0;
        end
        forever begin
            @(posedge clk);
            for (int d = 0; d < 3; d++) begin
                if (!rst_n) begin
                    m_sum[d] = '0; m_busy[d] = 0; m_done[d] = 0; m_cout[d] = 0;
                    m_ovf[d] = 0; m_zero[d] = 0; m_rem[d] = 0;
                end else if (m_busy[d]) begin
                    m_rem[d]--;
                    if (m_rem[d] == 0) finish_op(d);
                end else begin
                    m_done[d] = 1'b0;
                    if (start[d]) begin
                        m_a[d] = a; m_b[d] = b; m_sub[d] = sub; m_cin[d] = cin;
                        m_sat[d] = sat;
                        m_busy[d] = 1'b1;
                        m_rem[d]  = nch_of(d);
                    end
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    task automatic cmp(input int d, input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL d%0d_%s: got 0x%0h expected 0x%0h (t=%0t)", d, nm, got, exp, $time);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                for (int d = 0; d < 3; d++) begin
                    cmp(d, "sum",  dut_sum(d),     m_sum[d]);
                    cmp(d, "cout", 32'(cout_o[d]), 32'(m_cout[d]));
                    cmp(d, "ovf",  32'(ovf_o[d]),  32'(m_ovf[d]));
                    cmp(d, "zero", 32'(zero_o[d]), 32'(m_zero[d]));
                    cmp(d, "busy", 32'(busy_o[d]), 32'(m_busy[d]));
                    cmp(d, "done", 32'(done_o[d]), 32'(m_done[d]));
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    // Entered at #1 after a rising edge; returns #1 after the completion edge.
    task automatic run_op(input int d, input logic [31:0] av, input logic [31:0] bv,
                          input logic sv, input logic cv, input logic satv);
        int lat;
        a = av; b = bv; sub = sv; cin = cv; sat = satv;
        start[d] = 1'b1;
        @(posedge clk); #1;
        start[d] = 1'b0;
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (done_o[d]) begin
                lat = i;
                break;
            end
        end
        chk($sformatf("d%0d_latency", d), 32'(lat), 32'(nch_of(d)));
    endtask

    task automatic chk_res(input int d, input string nm, input logic [31:0] es,
                           input logic ec, input logic eo, input logic ez);
        chk({nm, "_sum"},       dut_sum(d),     es);
        chk({nm, "_cout"},      32'(cout_o[d]), 32'(ec));
        chk({nm, "_ovf"},       32'(ovf_o[d]),  32'(eo));
        chk({nm, "_zero"},      32'(zero_o[d]), 32'(ez));
        chk({nm, "_model_sum"}, m_sum[d],       es);
        chk({nm, "_model_ovf"}, 32'(m_ovf[d]),  32'(eo));
    endtask

    initial begin
        int   lat;
        logic satv;
        rst_n = 1'b0; start = '0; sub = 0; cin = 0; sat = 0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("reset_sum_d%0d", d),  dut_sum(d),     32'd0);
            chk($sformatf("reset_busy_d%0d", d), 32'(busy_o[d]), 32'd0);
            chk($sformatf("reset_done_d%0d", d), 32'(done_o[d]), 32'd0);
        end
        chk_en = 1'b1;
        rst_n  = 1'b1;
        @(posedge clk); #1;

        run_op(0, 32'h7FFF, 32'h0001, 0, 0, 0); chk_res(0, "add_ovf",  32'h8000, 0, 1, 0);
        run_op(0, 32'h0005, 32'h0007, 1, 0, 0); chk_res(0, "sub_borrow", 32'hFFFE, 0, 0, 0);
        run_op(0, 32'h0007, 32'h0005, 1, 1, 0); chk_res(0, "sub_cin",  32'h0001, 1, 0, 0);
        run_op(0, 32'hFFFF, 32'h0001, 0, 0, 0); chk_res(0, "add_zero", 32'h0000, 1, 0, 1);
        repeat (3) begin
            @(posedge clk); #1;
            chk("idle_hold_sum", dut_sum(0), 32'h0000);
        end
        run_op(0, 32'h8000, 32'h0001, 1, 0, 0); chk_res(0, "sub_ovf",  32'h7FFF, 1, 1, 0);

        // Reset two edges into an operation: aborted, cleared, no Done
        a = 32'h1111; b = 32'h2222; sub = 0; cin = 0; start[0] = 1'b1;
        @(posedge clk); #1;
        start[0] = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("rst_mid_busy", 32'(busy_o[0]), 32'd0);
        chk("rst_mid_sum",  dut_sum(0),     32'd0);
        chk("rst_mid_done", 32'(done_o[0]), 32'd0);
        rst_n = 1'b1;
        repeat (6) begin
            @(posedge clk); #1;
            chk("rst_mid_no_done", 32'(done_o[0]), 32'd0);
        end

        // Start during CALC is ignored; original operands complete on schedule
        a = 32'h1234; b = 32'h1111; sub = 0; cin = 0; start[0] = 1'b1;
        @(posedge clk); #1;
        a = 32'hFFFF; b = 32'hFFFF; sub = 1;
        @(posedge clk); #1;
        start[0] = 1'b0;
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (done_o[0]) begin
                lat = i;
                break;
            end
        end
        chk("ignore_lat", 32'(lat), 32'd3);
        chk_res(0, "ignore", 32'h2345, 0, 0, 0);

        run_op(1, 32'hFFFF, 32'h0001, 0, 0, 0); chk_res(1, "c16_zero", 32'h0000, 1, 0, 1);
        run_op(1, 32'h7FFF, 32'h0001, 0, 0, 0); chk_res(1, "c16_ovf",  32'h8000, 0, 1, 0);
        run_op(1, 32'h0005, 32'h0007, 1, 0, 0); chk_res(1, "c16_sub",  32'hFFFE, 0, 0, 0);

        run_op(2, 32'h7FFFFFFF, 32'h1, 0, 0, 0); chk_res(2, "w32_ovf", 32'h80000000, 0, 1, 0);
        run_op(2, 32'h0, 32'h1, 1, 0, 0);        chk_res(2, "w32_sub", 32'hFFFFFFFF, 0, 0, 0);

`ifdef ADDSUB_SAT_EN
        run_op(0, 32'h7FFF, 32'h0001, 0, 0, 1); chk_res(0, "sat_pos", 32'h7FFF, 0, 1, 0);
        run_op(0, 32'h8000, 32'h0001, 1, 0, 1); chk_res(0, "sat_neg", 32'h8000, 1, 1, 0);
        run_op(0, 32'h7FFF, 32'h0001, 0, 0, 0); chk_res(0, "nosat_pos", 32'h8000, 0, 1, 0);
        run_op(0, 32'h8000, 32'h0001, 1, 0, 0); chk_res(0, "nosat_neg", 32'h7FFF, 1, 1, 0);
`endif

        // Random traffic, mixing back-to-back and idle-gapped starts
        for (int d = 0; d < 3; d += 2) begin
            repeat (100) begin
                if ($urandom_range(0, 3) == 0) begin
                    repeat ($urandom_range(1, 3)) @(posedge clk);
                    #1;
                end
                satv = 1'b0;
`ifdef ADDSUB_SAT_EN
                satv = 1'($urandom_range(0, 1));
`endif
                run_op(d, $urandom, $urandom, 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)), satv);
            end
        end

        repeat (3) @(posedge clk);
        #1;
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/multicycle_addsub.md
Name: multicycle_addsub

Overview:
- Parametrised, chunk-serial signed/unsigned adder-subtractor.
- Computes Sum = A ± B ± carry over WIDTH/CHUNK clock cycles, CHUNK bits per cycle, LSB chunk first, with the carry held in a register between chunks.
- Successor to the combinational word carry-lookahead adder. Serves ALU paths wider than one cycle's carry budget.
- Start/Busy/Done handshake plus flag outputs: COut, Overflow, Zero.

Parameters:
- WIDTH, 16, operand and result width; must be a multiple of CHUNK.
- CHUNK, 4, bits added per cycle; range 1..WIDTH.
- NCH = WIDTH/CHUNK is a derived localparam (chunk count). It is not overridable.

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
- Start  input  1  request; sampled only in IDLE or DONE.
- Sub  input  1  0 = add, 1 = subtract; latched with Start.
- CIn  input  1  carry-in (add) or borrow-in (sub); latched with Start.
- A  input  WIDTH  operand A; latched with Start.
- B  input  WIDTH  operand B; latched with Start.
- Sum  output  WIDTH  result register.
- COut  output  1  raw carry out of the MSB.
- Overflow  output  1  two's-complement overflow.
- Zero  output  1  Sum == 0.
- Busy  output  1  operation in progress.
- Done  output  1  one-cycle completion pulse.

Behaviour:
- Interface (decided): one clock, clk. Reset rst_n is synchronous and active-low. While rst_n==0 at an edge: state=IDLE; Sum=0, COut=0, Overflow=0, Zero=0, Busy=0, Done=0; operand, chunk-index and carry registers cleared.
- States: IDLE, CALC, DONE.
- IDLE: Start=1 at edge k
  - latch A; latch B' = Sub ? ~B : B;
  - carry = CIn ^ Sub;
  - chunk index i = 0; go to CALC; Busy=1 from edge k.
- CALC: each edge adds chunk i of A and B' with the carry register.
  - Writes the CHUNK-bit partial result into an internal shadow register.
  - Updates the carry; i increments.
  - On the edge processing i = NCH-1:
    - copy the shadow register to Sum;
    - COut = final carry;
    - Overflow = carry-into-MSB XOR carry-out-of-MSB;
    - Zero = (final Sum == 0);
    - Busy=0, Done=1; go to DONE.
  - This edge is k+NCH, giving latency NCH cycles Start-to-Done.
- Sum, COut, Overflow and Zero change only on the completion edge (or reset). Partial results are never visible. Outputs hold until the next completion.
- DONE: lasts exactly one cycle; Done=1.
  - Start=1 here is accepted exactly as in IDLE (back-to-back): CALC, Busy=1, Done=0 next cycle.
  - Otherwise return to IDLE; Done=0.
- Start while in CALC: ignored. Operand inputs in CALC are don't-care.
- Subtract convention: A - B - CIn. COut=1 means no borrow.
- CHUNK == WIDTH: NCH=1, single-cycle compute; Done one cycle after Start.
- Reset mid-operation: operation aborted, outputs cleared as above, no Done pulse.
- Reset has priority over Start on the same edge.

Optional Feature:
- Macro: ADDSUB_SAT_EN
- Defined:
  - Adds input port Sat (1 bit), latched with Start.
  - If Sat=1 and Overflow=1 at completion, Sum is clamped: latched A[WIDTH-1]==0 gives {0,1...1}; A[WIDTH-1]==1 gives {1,0...0}.
  - Overflow still reports 1. COut is unclamped. Zero is computed on the clamped Sum.
- Undefined: no Sat port; results always wrap modulo 2^WIDTH.

Test Plan (WIDTH=16, CHUNK=4 unless stated):
- Add A=0x7FFF, B=0x0001, Sub=0, CIn=0, Start at edge k -> at edge k+4: Sum=0x8000, Overflow=1, COut=0, Zero=0, Done high one cycle, Busy high edges k..k+3.
- Sub A=0x0005, B=0x0007, CIn=0 -> Sum=0xFFFE, COut=0 (borrow), Overflow=0; then A=0x0007, B=0x0005, CIn=1 -> Sum=0x0001, COut=1.
- Add A=0xFFFF, B=0x0001 -> Sum=0x0000, COut=1, Zero=1, Overflow=0; Sum stays 0x0000 in the idle cycles afterward.
- Start, then rst_n=0 at edge k+2 -> after that edge Busy=0, Sum=0, no Done pulse. Start at k+1 (during CALC) ignored. Start in the DONE cycle -> second result exactly 4 edges later. Repeat with CHUNK=16: Done at k+1.
- 100 random A/B/Sub/CIn, WIDTH=16 and WIDTH=32/CHUNK=8 -> {COut,Sum} equals the reference-model sum. Overflow equals the sign-rule prediction.
- ADDSUB_SAT_EN, Sat=1:
  - A=0x7FFF+0x0001 -> Sum=0x7FFF, Overflow=1.
  - A=0x8000-0x0001 -> Sum=0x8000, Overflow=1.
  - Sat=0 on the same operands -> 0x8000 and 0x7FFF.
